matrix_engine_seq: RTL and testbench

Parametrised, sequential NxN matrix unit that computes either C = A + B or C = A x B on packed operand buses. It supersedes the separate combinational 2x2 adder and multiplier with one shared datapath that uses a single adder/multiplier-accumulator, stepped by counters. It has a valid/ready handshake on input and on output, so it can sit between a packed-matrix source and a result consumer with back-pressure.

---
 rtl/matrix_pkg.sv | 23 ++
 rtl/matrix_mac_unit.sv | 27 ++
 rtl/matrix_engine_seq.sv | 130 +++++++++++++
 tb/tb_matrix_engine_seq.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared definitions for the sequential matrix engine: mode encoding, FSM states
// and helpers for packed-bus element offsets and result width.
package matrix_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_MUL = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    DONE
  } state_t;

  // LSB position of element (r,c) on a row-major bus with element (0,0) in the MSBs
  function automatic int elem_offset(input int r, input int c, input int n, input int w);
    return (n * n - 1 - (r * n + c)) * w;
  endfunction

  function automatic int calc_cw(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction

endpackage

// File: rtl/matrix_mac_unit.sv
// Combinational datapath shared by both modes: one DW x DW multiplier feeding a
// CW-wide adder. Add mode bypasses the multiplier and sums the two operands.
module matrix_mac_unit
  import matrix_pkg::*;
#(
  parameter int DW = 2,
  parameter int CW = 5
) (
  input  logic          mode,
  input  logic [DW-1:0] a_elem,
  input  logic [DW-1:0] b_elem,
  input  logic [CW-1:0] acc,
  output logic [CW-1:0] result
);

  logic [2*DW-1:0] product;

  always_comb begin
    product = {{DW{1'b0}}, a_elem} * {{DW{1'b0}}, b_elem};
    if (mode == MODE_MUL) begin
      result = acc + CW'(product);
    end else begin
      result = CW'(a_elem) + CW'(b_elem);
    end
  end

endmodule

// File: rtl/matrix_engine_seq.sv
// Sequential NxN matrix add/multiply with valid/ready on both sides. One element
// operation per cycle through a shared MAC, stepped by i/j/k counters.
module matrix_engine_seq
  import matrix_pkg::*;
#(
  parameter  int N  = 2,
  parameter  int DW = 2,
  localparam int CW = calc_cw(N, DW)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mode,
  input  logic [N*N*DW-1:0] a_flat,
  input  logic [N*N*DW-1:0] b_flat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N*N*CW-1:0] c_flat,
  output logic              busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t            state;
  logic [N*N*DW-1:0] a_reg;
  logic [N*N*DW-1:0] b_reg;
  logic              mode_reg;
  logic [IW-1:0]     i;
  logic [IW-1:0]     j;
  logic [IW-1:0]     k;
  logic [CW-1:0]     acc;

  logic [DW-1:0]     a_sel;
  logic [DW-1:0]     b_sel;
  logic [CW-1:0]     mac_result;
  int                c_off;

  // Add walks A[i][j]+B[i][j]; multiply walks A[i][k]*B[k][j]
  always_comb begin
    c_off = elem_offset(int'(i), int'(j), N, CW);
    if (mode_reg == MODE_MUL) begin
      a_sel = a_reg[elem_offset(int'(i), int'(k), N, DW) +: DW];
      b_sel = b_reg[elem_offset(int'(k), int'(j), N, DW) +: DW];
    end else begin
      a_sel = a_reg[elem_offset(int'(i), int'(j), N, DW) +: DW];
      b_sel = b_reg[elem_offset(int'(i), int'(j), N, DW) +: DW];
    end
  end

  matrix_mac_unit #(
    .DW(DW),
    .CW(CW)
  ) u_mac (
    .mode  (mode_reg),
    .a_elem(a_sel),
    .b_elem(b_sel),
    .acc   (acc),
    .result(mac_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      c_flat    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      mode_reg  <= MODE_ADD;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      acc       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_reg    <= a_flat;
            b_reg    <= b_flat;
            mode_reg <= mode;
            i        <= '0;
            j        <= '0;
            k        <= '0;
            acc      <= '0;
            c_flat   <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= COMPUTE;
          end
        end
        COMPUTE: begin
          // Multiply only writes C once the k-sum is complete
          if (mode_reg == MODE_MUL && k != LAST) begin
            acc <= mac_result;
            k   <= k + IW'(1);
          end else begin
            c_flat[c_off +: CW] <= mac_result;
            acc <= '0;
            k   <= '0;
            if (j != LAST) begin
              j <= j + IW'(1);
            end else begin
              j <= '0;
              if (i != LAST) begin
                i <= i + IW'(1);
              end else begin
                i         <= '0;
                busy      <= 1'b0;
                out_valid <= 1'b1;
                state     <= DONE;
              end
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_engine_seq.sv
// Self-checking bench for matrix_engine_seq: directed cases with literal results,
// randomized traffic checked every cycle against a behavioural timeline model.
module tb_matrix_engine_seq;

  localparam int N   = 2;
  localparam int DW  = 2;
  localparam int CW  = 5;
  localparam int DW2 = 3;
  localparam int CW2 = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic              in_valid = 1'b0;
  logic              mode = 1'b0;
  logic [N*N*DW-1:0] a_flat = '0;
  logic [N*N*DW-1:0] b_flat = '0;
  logic              out_ready = 1'b0;
  logic              in_ready;
  logic              out_valid;
  logic              busy;
  logic [N*N*CW-1:0] c_flat;

  logic               in_valid2 = 1'b0;
  logic               mode2 = 1'b0;
  logic [N*N*DW2-1:0] a2 = '0;
  logic [N*N*DW2-1:0] b2 = '0;
  logic               out_ready2 = 1'b0;
  logic               in_ready2;
  logic               out_valid2;
  logic               busy2;
  logic [N*N*CW2-1:0] c2;

  int total = 0;
  int bad = 0;

  // Behavioural model: 0 = waiting for operands, 1 = computing, 2 = result held
  int                m_phase = 0;
  int                m_left = 0;
  logic [N*N*CW-1:0] m_exp = '0;
  logic [N*N*CW-1:0] m_c = '0;

  always #5 clk = ~clk;

  matrix_engine_seq #(.N(N), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .a_flat   (a_flat),
    .b_flat   (b_flat),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .c_flat   (c_flat),
    .busy     (busy)
  );

  matrix_engine_seq #(.N(N), .DW(DW2)) dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid2),
    .in_ready (in_ready2),
    .mode     (mode2),
    .a_flat   (a2),
    .b_flat   (b2),
    .out_valid(out_valid2),
    .out_ready(out_ready2),
    .c_flat   (c2),
    .busy     (busy2)
  );

  function automatic logic [N*N*CW-1:0] ref_result(input logic m,
                                                   input logic [N*N*DW-1:0] a,
                                                   input logic [N*N*DW-1:0] b);
    int ea [N][N];
    int eb [N][N];
    int s;
    logic [N*N*CW-1:0] res;
    res = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        ea[r][c] = int'(a[(N*N-1-(r*N+c))*DW +: DW]);
        eb[r][c] = int'(b[(N*N-1-(r*N+c))*DW +: DW]);
      end
    end
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (!m) begin
          s = ea[r][c] + eb[r][c];
        end else begin
          s = 0;
          for (int x = 0; x < N; x++) s += ea[r][x] * eb[x][c];
        end
        res[(N*N-1-(r*N+c))*CW +: CW] = CW'(s);
      end
    end
    return res;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_left  = 0;
      m_c     = '0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
             m_exp   = ref_result(mode, a_flat, b_flat);
             m_left  = mode ? N*N*N : N*N;
             m_c     = '0;
             m_phase = 1;
           end
        1: begin
             m_left--;
             if (m_left == 0) begin
               m_phase = 2;
               m_c     = m_exp;
             end
           end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    checkOutput("in_ready", 64'(in_ready), 64'(m_phase == 0));
    checkOutput("busy", 64'(busy), 64'(m_phase == 1));
    checkOutput("out_valid", 64'(out_valid), 64'(m_phase == 2));
    if (m_phase != 1) checkOutput("c_flat", 64'(c_flat), 64'(m_c));
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic m, input logic [N*N*DW-1:0] a,
                               input logic [N*N*DW-1:0] b, output int lat);
    int guard;
    guard = 0;
    step();
    while (!in_ready && guard < 100) begin
      step();
      guard++;
    end
    checkOutput("accept_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    mode = m;
    a_flat = a;
    b_flat = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic releaseResult();
    step();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("release_in_ready", 64'(in_ready), 64'd1);
    checkOutput("release_out_valid", 64'(out_valid), 64'd0);
  endtask

  task automatic applyStimulus2(input logic m, input logic [N*N*DW2-1:0] a,
                                input logic [N*N*DW2-1:0] b, output int lat);
    step();
    checkOutput("dw3_accept_ready", 64'(in_ready2), 64'd1);
    in_valid2 = 1'b1;
    mode2 = m;
    a2 = a;
    b2 = b;
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    lat = 0;
    while (!out_valid2 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic releaseResult2();
    step();
    out_ready2 = 1'b1;
    @(posedge clk);
    #1;
    out_ready2 = 1'b0;
    checkOutput("dw3_release_in_ready", 64'(in_ready2), 64'd1);
  endtask

  localparam logic [7:0]  A0 = 8'b00_01_10_11;
  localparam logic [7:0]  B0 = 8'b01_00_11_01;
  localparam logic [19:0] C_MUL = 20'b00011_00001_01011_00011;
  localparam logic [19:0] C_ADD = {5'd1, 5'd1, 5'd5, 5'd4};
  localparam logic [19:0] C_MAX = {4{5'd18}};

  initial begin
    int lat;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_c_flat", 64'(c_flat), 64'd0);
    step();
    rst_n = 1'b1;

    // Wider-element instance: add and all-max multiply
    applyStimulus2(1'b0, {3'd2, 3'd3, 3'd4, 3'd5}, {3'd1, 3'd2, 3'd3, 3'd4}, lat);
    checkOutput("dw3_add_latency", 64'(lat), 64'd4);
    checkOutput("dw3_add_c", 64'(c2), 64'({7'd3, 7'd5, 7'd7, 7'd9}));
    releaseResult2();
    applyStimulus2(1'b1, 12'hFFF, 12'hFFF, lat);
    checkOutput("dw3_max_latency", 64'(lat), 64'd8);
    checkOutput("dw3_max_c", 64'(c2), 64'({4{7'd98}}));
    releaseResult2();

    applyStimulus(1'b1, A0, B0, lat);
    checkOutput("mul_latency", 64'(lat), 64'd8);
    checkOutput("mul_c", 64'(c_flat), 64'(C_MUL));

    // Hold the result and offer new operands; both must be ignored
    for (int n = 0; n < 5; n++) begin
      step();
      in_valid = 1'b1;
      mode = 1'b0;
      a_flat = 8'hFF;
      b_flat = 8'hAA;
      checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
      checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
      checkOutput("bp_c", 64'(c_flat), 64'(C_MUL));
    end
    step();
    in_valid = 1'b0;
    checkOutput("bp_c_final", 64'(c_flat), 64'(C_MUL));
    releaseResult();

    applyStimulus(1'b0, A0, B0, lat);
    checkOutput("add_latency", 64'(lat), 64'd4);
    checkOutput("add_c", 64'(c_flat), 64'(C_ADD));
    releaseResult();

    applyStimulus(1'b1, 8'hFF, 8'hFF, lat);
    checkOutput("max_latency", 64'(lat), 64'd8);
    checkOutput("max_c", 64'(c_flat), 64'(C_MAX));
    releaseResult();

    // Abort a multiply on its third compute cycle
    step();
    in_valid = 1'b1;
    mode = 1'b1;
    a_flat = A0;
    b_flat = B0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
    checkOutput("abort_c", 64'(c_flat), 64'd0);
    checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    step();
    rst_n = 1'b1;
    applyStimulus(1'b1, A0, B0, lat);
    checkOutput("post_abort_latency", 64'(lat), 64'd8);
    checkOutput("post_abort_c", 64'(c_flat), 64'(C_MUL));
    releaseResult();

    // Random traffic with occasional resets, judged by the per-cycle model
    for (int n = 0; n < 3000; n++) begin
      step();
      rst_n = ($urandom_range(0, 199) != 0);
      in_valid = $urandom_range(0, 1) == 1;
      mode = $urandom_range(0, 1) == 1;
      a_flat = 8'($urandom);
      b_flat = 8'($urandom);
      out_ready = ($urandom_range(0, 2) == 0);
    end
    step();
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (12) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
